y_collect_reg: RTL and testbench
================================

Name: y_collect_reg

Overview:
- Output-side counterpart of the per-row input skew registers on the 8x8 systolic array.
- The input registers are written by index and shifted out serially. This block works the other way: it captures one column's serial PE output stream, packing only valid samples, into a DEPTH-entry buffer.
- Once the expected count is captured, it exposes the contents for indexed, registered read-out by the controller or writeback path.
- One instance per array column.

Parameters:
- DATA_W, 16, width of PE result samples (signed two's complement).
- DEPTH, 32, buffer entries; must be a power of two.
- IDX_W, 5, read index width; equals log2(DEPTH).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  capture enable; when 0, VALID_IN is ignored and counters hold.
- START  in  1  one-cycle pulse; clears the buffer state, latches LEN, enters CAPTURE.
- LEN  in  IDX_W+1  expected valid-sample count; sampled only on START; 0 means DEPTH.
- DIN  in  DATA_W  serial sample from the bottom PE of the column.
- VALID_IN  in  1  DIN qualifier.
- BUSY  out  1  high in CAPTURE.
- DONE  out  1  high in READY.
- COUNT  out  IDX_W+1  number of samples captured since the last START.
- OVERFLOW  out  1  sticky; set when a valid sample is dropped.
- RD_EN  in  1  read request.
- RD_IDX  in  IDX_W  read address.
- RD_DATA  out  DATA_W  registered read data.
- RD_VALID  out  1  one-cycle strobe that qualifies RD_DATA.
- RELEASE  in  1  READY -> IDLE; the consumer is finished with the buffer.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State goes to IDLE.
  - COUNT=0, target=DEPTH, OVERFLOW=0, RD_DATA=0, RD_VALID=0, BUSY=0, DONE=0.
  - Buffer contents are cleared to 0.
  - Reset has priority over every other input, including mid-CAPTURE and mid-read.
- FSM states: IDLE, CAPTURE, READY. BUSY and DONE are decoded directly from state.
- IDLE:
  - START -> CAPTURE, with COUNT=0, target=LEN (0 maps to DEPTH), OVERFLOW=0.
  - VALID_IN is ignored, and does not set OVERFLOW.
- CAPTURE:
  - When EN && VALID_IN: buf[COUNT] <= DIN and COUNT <= COUNT+1.
  - Invalid cycles leave a gap in time only; nothing is stored, so samples are packed.
  - When the captured sample makes COUNT equal target, state -> READY on the same edge that COUNT updates.
  - EN=0 freezes capture completely.
- READY:
  - Buffer contents and COUNT are frozen.
  - EN && VALID_IN drops the sample and sets OVERFLOW.
  - RELEASE -> IDLE. COUNT and contents are retained until the next START.
- START in CAPTURE or READY restarts capture: COUNT=0, new LEN latched, OVERFLOW cleared.
- START and RELEASE in the same cycle: START wins.
- START and a valid sample in the same cycle: the sample is discarded, and OVERFLOW is not set.
- Read port:
  - Reads are served only in READY.
  - RD_EN in READY: on the next cycle, RD_VALID=1 and RD_DATA=buf[RD_IDX]. Latency is 1 cycle; back-to-back reads are allowed every cycle.
  - RD_IDX >= COUNT returns 0 with RD_VALID=1.
  - RD_EN outside READY: RD_VALID=0 and RD_DATA holds its previous value.
  - A read issued in the same cycle as RELEASE is still served.
- Wrap-around is not possible: COUNT never exceeds target, which is at most DEPTH.

Optional Feature:
- Macro: Y_COLLECT_RELU_EN.
- Defined: each captured sample is stored as (DIN[DATA_W-1] ? 0 : DIN), i.e. ReLU applied at capture. OVERFLOW behaviour is unchanged.
- Undefined: DIN is stored unmodified.
- Read timing and latency are identical in both builds.

Test Plan:
1. Reset, START with LEN=4, then samples 0x0011, 0x0022, 0x0033, 0x0044 on consecutive valid cycles -> BUSY for 4 cycles; DONE rises on the edge capturing 0x0044; COUNT=4; reads of idx 0..3 return 0x0011..0x0044, one cycle after each RD_EN.
2. START with LEN=3; VALID_IN pattern 1,0,0,1,0,1 with DIN=0x0A,x,x,0x0B,x,0x0C -> buffer holds 0A,0B,0C packed at idx 0..2; a read at idx 5 returns 0 with RD_VALID=1.
3. START with LEN=0 and 32 valid samples of value i -> DONE only after the 32nd sample, COUNT=32; a further valid sample sets OVERFLOW=1 and buf[31] stays 31.
4. In CAPTURE after 2 of 4 samples, assert RST -> next cycle state is IDLE, COUNT=0, DONE=0, RD_VALID=0; START with LEN=2 afterwards captures correctly from idx 0.
5. In READY, assert START and RELEASE together with LEN=1 -> state is CAPTURE with COUNT=0 and OVERFLOW=0; RD_EN on the following cycle gives RD_VALID=0.
6. With Y_COLLECT_RELU_EN defined, capture 0xFFF0 then 0x0005 (LEN=2) -> reads return 0x0000 and 0x0005; without the macro they return 0xFFF0 and 0x0005.

Source files
------------

// File: rtl/y_collect_reg.sv
// ---------------------------------------------------------------------------
// y_collect_reg
//   Collects one systolic-array column's serial PE output stream into a
//   DEPTH-entry buffer. Only valid samples are stored, packed from index 0.
//   Once the expected count has been captured, the buffer is frozen and
//   exposed through a registered, indexed read port. One instance per column.
//
//   Optional build macro: Y_COLLECT_RELU_EN
//     defined   -> samples are clamped at zero (ReLU) as they are captured
//     undefined -> samples are stored unmodified
//
// Ports
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   EN        capture enable; 0 ignores VALID_IN and holds counters
//   START     one-cycle pulse: restart capture, latch LEN
//   LEN       expected valid-sample count (0 means DEPTH)
//   DIN       serial sample from the bottom PE of the column
//   VALID_IN  DIN qualifier
//   BUSY      high while capturing
//   DONE      high while the buffer is ready for read-out
//   COUNT     samples captured since the last START
//   OVERFLOW  sticky: a valid sample arrived after the buffer was full
//   RD_EN     read request (served only while DONE)
//   RD_IDX    read address
//   RD_DATA   registered read data
//   RD_VALID  one-cycle strobe qualifying RD_DATA
//   RELEASE   consumer is finished; READY -> IDLE
// ---------------------------------------------------------------------------
module y_collect_reg #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  input  logic [IDX_W:0]    LEN,
  input  logic [DATA_W-1:0] DIN,
  input  logic              VALID_IN,
  output logic              BUSY,
  output logic              DONE,
  output logic [IDX_W:0]    COUNT,
  output logic              OVERFLOW,
  input  logic              RD_EN,
  input  logic [IDX_W-1:0]  RD_IDX,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  input  logic              RELEASE
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READY   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W:0]    count_q;
  logic [IDX_W:0]    target_q;
  logic              overflow_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic [IDX_W:0]    count_inc;
  logic [IDX_W:0]    len_target;
  logic [DATA_W-1:0] din_s;
  logic              accept;
  logic              drop;
  logic              rd_fire;
  logic              rd_hit;

  assign count_inc = count_q + 1'b1;

  // LEN of 0 selects a full buffer. Values above DEPTH are clamped so that
  // COUNT can never run past the last entry.
  assign len_target = ((LEN == '0) || (LEN > DEPTH_C)) ? DEPTH_C : LEN;

`ifdef Y_COLLECT_RELU_EN
  assign din_s = DIN[DATA_W-1] ? '0 : DIN;
`else
  assign din_s = DIN;
`endif

  // Next state and per-cycle capture/drop decisions. START overrides
  // everything else, which also discards any sample arriving with it.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    if (START) begin
      state_d = S_CAPTURE;
    end else begin
      case (state_q)
        S_CAPTURE: begin
          if (EN && VALID_IN) begin
            accept = 1'b1;
            if (count_inc == target_q) state_d = S_READY;
          end
        end
        S_READY: begin
          if (EN && VALID_IN) drop = 1'b1;
          if (RELEASE) state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      target_q   <= DEPTH_C;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (START) begin
        count_q    <= '0;
        target_q   <= len_target;
        overflow_q <= 1'b0;
      end else begin
        if (accept) count_q    <= count_inc;
        if (drop)   overflow_q <= 1'b1;
      end
    end
  end

  // Sample buffer. In CAPTURE count_q < target_q <= DEPTH, so the low
  // IDX_W bits always address a real entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[count_q[IDX_W-1:0]] <= din_s;
    end
  end

  // Read port: served in READY only (including the RELEASE cycle).
  // Addresses past COUNT return zero instead of stale data.
  assign rd_fire = RD_EN && (state_q == S_READY);
  assign rd_hit  = ({1'b0, RD_IDX} < count_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_data_q <= rd_hit ? mem_q[RD_IDX] : '0;
    end
  end

  assign BUSY     = (state_q == S_CAPTURE);
  assign DONE     = (state_q == S_READY);
  assign COUNT    = count_q;
  assign OVERFLOW = overflow_q;
  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;

endmodule

// File: tb/tb_y_collect_reg.sv
module tb_y_collect_reg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int IDX_W  = 5;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              EN = 1'b1;
  logic              START = 1'b0;
  logic [IDX_W:0]    LEN = '0;
  logic [DATA_W-1:0] DIN = '0;
  logic              VALID_IN = 1'b0;
  logic              BUSY, DONE, OVERFLOW, RD_VALID;
  logic [IDX_W:0]    COUNT;
  logic              RD_EN = 1'b0;
  logic [IDX_W-1:0]  RD_IDX = '0;
  logic [DATA_W-1:0] RD_DATA;
  logic              RELEASE = 1'b0;

  int errors = 0;
  int checks = 0;

  y_collect_reg #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .LEN(LEN), .DIN(DIN),
    .VALID_IN(VALID_IN), .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .RD_EN(RD_EN), .RD_IDX(RD_IDX), .RD_DATA(RD_DATA),
    .RD_VALID(RD_VALID), .RELEASE(RELEASE)
  );

  always #5 CLK = ~CLK;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int len);
    START = 1'b1; LEN = len[IDX_W:0];
    tick();
    START = 1'b0;
  endtask

  task automatic sample(input int d);
    VALID_IN = 1'b1; DIN = d[DATA_W-1:0];
    tick();
    VALID_IN = 1'b0;
  endtask

  task automatic rd(input string tag, input int idx, input int exp);
    RD_EN = 1'b1; RD_IDX = idx[IDX_W-1:0];
    tick();
    RD_EN = 1'b0;
    chk({tag, "_vld"}, 32'(RD_VALID), 1);
    chk({tag, "_data"}, 32'(RD_DATA), exp);
  endtask

  initial begin
    int d1, d2;
    // ---------------- reset ----------------
    tick(); tick();
    RST = 1'b0;
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_ovf", 32'(OVERFLOW), 0);
    chk("rst_rdv", 32'(RD_VALID), 0);
    chk("rst_rdd", 32'(RD_DATA), 0);
    // valid samples in IDLE are ignored
    sample(16'h1234);
    chk("idle_ovf", 32'(OVERFLOW), 0);
    chk("idle_count", 32'(COUNT), 0);

    // ---------------- test 1: LEN=4, consecutive ----------------
    do_start(4);
    chk("t1_busy0", 32'(BUSY), 1);
    chk("t1_count0", 32'(COUNT), 0);
    for (int i = 1; i <= 4; i++) begin
      sample(i * 16'h0011);
      chk("t1_count", 32'(COUNT), i);
      chk("t1_busy", 32'(BUSY), (i < 4) ? 1 : 0);
      chk("t1_done", 32'(DONE), (i == 4) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) rd("t1_rd", i, (i + 1) * 16'h0011);
    tick();
    chk("t1_rdv_low", 32'(RD_VALID), 0);
    // read together with RELEASE is still served
    RD_EN = 1'b1; RD_IDX = 5'd1; RELEASE = 1'b1;
    tick();
    RELEASE = 1'b0;
    chk("t1_rel_rdv", 32'(RD_VALID), 1);
    chk("t1_rel_rdd", 32'(RD_DATA), 16'h0022);
    chk("t1_rel_done", 32'(DONE), 0);
    // read in IDLE: no strobe, data holds
    RD_IDX = 5'd3;
    tick();
    RD_EN = 1'b0;
    chk("t1_idle_rdv", 32'(RD_VALID), 0);
    chk("t1_idle_rdd", 32'(RD_DATA), 16'h0022);
    chk("t1_idle_count", 32'(COUNT), 4);

    // ---------------- test 2: packed with gaps, EN=0 hold ----------------
    do_start(3);
    sample(16'h000A);
    tick(); tick();
    EN = 1'b0;
    sample(16'h00EE);          // frozen: not captured
    EN = 1'b1;
    chk("t2_en0_count", 32'(COUNT), 1);
    sample(16'h000B);
    tick();
    sample(16'h000C);
    chk("t2_done", 32'(DONE), 1);
    chk("t2_count", 32'(COUNT), 3);
    rd("t2_rd0", 0, 16'h000A);
    rd("t2_rd1", 1, 16'h000B);
    rd("t2_rd2", 2, 16'h000C);
    rd("t2_rd3", 3, 0);        // entry 3 still holds 0x44, but is past COUNT
    rd("t2_rd5", 5, 0);

    // ---------------- test 3: LEN=0 -> full depth, overflow ----------------
    do_start(0);
    for (int i = 0; i < DEPTH; i++) begin
      sample(i);
      chk("t3_done", 32'(DONE), (i == DEPTH - 1) ? 1 : 0);
    end
    chk("t3_count", 32'(COUNT), DEPTH);
    chk("t3_ovf0", 32'(OVERFLOW), 0);
    sample(16'h0099);
    chk("t3_ovf1", 32'(OVERFLOW), 1);
    chk("t3_count_hold", 32'(COUNT), DEPTH);
    rd("t3_rd31", 31, 31);
    rd("t3_rd0", 0, 0);
    // START with a valid sample: sample discarded, overflow cleared
    START = 1'b1; LEN = 6'd2; VALID_IN = 1'b1; DIN = 16'h0077;
    tick();
    START = 1'b0; VALID_IN = 1'b0;
    chk("t3_rs_busy", 32'(BUSY), 1);
    chk("t3_rs_count", 32'(COUNT), 0);
    chk("t3_rs_ovf", 32'(OVERFLOW), 0);

    // ---------------- test 4: reset mid-capture ----------------
    do_start(4);
    sample(16'h0001);
    sample(16'h0002);
    chk("t4_mid_count", 32'(COUNT), 2);
    RST = 1'b1; VALID_IN = 1'b1; DIN = 16'h0003;
    tick();
    RST = 1'b0; VALID_IN = 1'b0;
    chk("t4_busy", 32'(BUSY), 0);
    chk("t4_done", 32'(DONE), 0);
    chk("t4_count", 32'(COUNT), 0);
    chk("t4_rdv", 32'(RD_VALID), 0);
    do_start(2);
    sample(16'h005A);
    sample(16'h005B);
    chk("t4_done2", 32'(DONE), 1);
    rd("t4_rd0", 0, 16'h005A);
    rd("t4_rd1", 1, 16'h005B);

    // ---------------- test 5: START + RELEASE in READY ----------------
    START = 1'b1; RELEASE = 1'b1; LEN = 6'd1;
    tick();
    START = 1'b0; RELEASE = 1'b0;
    chk("t5_busy", 32'(BUSY), 1);
    chk("t5_done", 32'(DONE), 0);
    chk("t5_count", 32'(COUNT), 0);
    chk("t5_ovf", 32'(OVERFLOW), 0);
    RD_EN = 1'b1; RD_IDX = 5'd0;
    tick();
    RD_EN = 1'b0;
    chk("t5_rdv", 32'(RD_VALID), 0);
    chk("t5_rdd_hold", 32'(RD_DATA), 16'h005B);

    // ---------------- test 6: ReLU build option ----------------
    do_start(2);
    sample(16'hFFF0);
    sample(16'h0005);
    chk("t6_done", 32'(DONE), 1);
`ifdef Y_COLLECT_RELU_EN
    d1 = 16'h0000;
`else
    d1 = 16'hFFF0;
`endif
    d2 = 16'h0005;
    rd("t6_rd0", 0, d1);
    rd("t6_rd1", 1, d2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
